rmw_shift_seq: RTL and testbench
================================

RMW_SHIFT_SEQ -- requirements
Module: rmw_shift_seq

Interface
REQ-001 SHALL have parameter DBW, default 16, meaning the operand/result data width.
REQ-002 SHALL have parameter AWB, default 24, meaning the memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a read-modify-write shift, sampled only in IDLE.
REQ-006 SHALL have port sz, input, 1 bit: 0 = 16-bit operand, 1 = 8-bit operand, captured at start.
REQ-007 SHALL have port op, input, 2 bits: 0=ASL, 1=ROL, 2=LSR, 3=ROR, captured at start.
REQ-008 SHALL have port ci, input, 1 bit: carry-in for ROL/ROR, captured at start.
REQ-009 SHALL have port addr, input, AWB bits: operand low-byte address, captured at start.
REQ-010 SHALL have the following memory-bus ports:
- cyc_o, output, 1 bit: bus request.
- we_o, output, 1 bit: write enable.
- adr_o, output, AWB bits: bus address.
- dat_o, output, 8 bits: write data.
- dat_i, input, 8 bits: read data.
- ack_i, input, 1 bit: bus cycle complete.
REQ-011 SHALL have the following status/result outputs:
- busy, output, 1 bit: sequencer not idle.
- done, output, 1 bit: one-cycle completion pulse.
- res_o, output, DBW bits: shifted result.
- n_o, z_o, c_o, output, 1 bit each: N, Z and C flags.

Function
REQ-012 SHALL implement states IDLE, RDLO, RDHI, MODIFY, WRHI, WRLO, FIN.
REQ-013 SHALL move IDLE->RDLO on start=1; busy SHALL be 1 in every state except IDLE.
REQ-014 SHALL hold cyc_o=1 throughout RDLO/RDHI/WRHI/WRLO (and MODIFY when the dummy write is enabled), and 0 in every other state.
REQ-015 SHALL hold each bus state until ack_i=1, then advance on that edge; stalls of any length SHALL be tolerated with adr_o, we_o and dat_o held stable.
REQ-016 SHALL latch dat_i into the operand low byte on ack in RDLO, and into the high byte on ack in RDHI.
REQ-017 SHALL go RDLO->MODIFY when sz=1 (skipping RDHI), and RDLO->RDHI when sz=0.
REQ-018 SHALL register the shift result and carry in MODIFY (one cycle, or until ack when the dummy write is enabled).
REQ-019 SHALL go MODIFY->WRHI when sz=0 and MODIFY->WRLO when sz=1; WRHI SHALL be followed by WRLO.
REQ-020 SHALL write the high result byte to addr+1 in WRHI and the low result byte to addr in WRLO (high byte first).
REQ-021 SHALL compute addr+1 modulo 2^AWB, so that all-ones wraps to 0.
REQ-022 SHALL go WRLO->FIN on ack; FIN SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-023 SHALL set flags as follows:
- n_o = result MSB (bit 7 when sz=1, bit DBW-1 when sz=0).
- z_o = 1 when the sized result is zero.
- c_o = the shifted-out bit.
REQ-024 SHALL force res_o[DBW-1:8] to 0 when sz=1.
REQ-025 SHALL hold res_o and the flags from FIN until the next operation's MODIFY.
REQ-026 SHALL ignore start while busy=1, including start asserted in FIN.
REQ-027 SHALL treat ack_i as don't-care whenever cyc_o=0.

Reset
REQ-028 SHALL, while rst=1, immediately force state=IDLE and cyc_o=we_o=busy=done=0.
REQ-029 SHALL, while rst=1, immediately force adr_o=0, dat_o=0, res_o=0 and n_o=z_o=c_o=0.
REQ-030 SHALL abandon any operation in progress on reset mid-operation, with no further bus cycles issued.

Configuration
REQ-031 With macro RMW_DUMMY_WRITE_EN defined, MODIFY SHALL be a bus write (cyc_o=1, we_o=1) of the unmodified low byte to addr, waiting for ack (6502 emulation behaviour).
REQ-032 Without RMW_DUMMY_WRITE_EN, MODIFY SHALL be a single internal cycle with cyc_o=0.

Structure
REQ-033 SHALL take the state encoding and the op codes (ASL/ROL/LSR/ROR) from the shared cpu package.
REQ-034 SHALL instantiate the existing shift unit as its one sub-module (shiftUnit, DBW passed through) rather than reimplementing the shift.

Verification
REQ-035 SHALL verify: sz=1, op=ASL, addr=0x001234, memory 0x81, zero-wait ack -> writes 0x02 to 0x001234, c_o=1, n_o=0, z_o=0, done pulses once.
REQ-036 SHALL verify: sz=0, op=ROR, ci=1, [0x10]=0x01, [0x11]=0x00 -> writes 0x80 to 0x11 then 0x00 to 0x10; res_o=0x8000, c_o=1, n_o=1.
REQ-037 SHALL verify: sz=0, addr=0xFFFFFF -> high-byte accesses at 0x000000, low-byte accesses at 0xFFFFFF.
REQ-038 SHALL verify: ack_i delayed 3 cycles on every access -> bus outputs stable through each stall, final result unchanged.
REQ-039 SHALL verify: rst pulsed during WRHI -> cyc_o drops in the same cycle, busy=0, no WRLO write occurs; a subsequent start completes normally.
REQ-040 SHALL verify: sz=1, op=LSR, value 0x01, built with and without RMW_DUMMY_WRITE_EN -> extra write of 0x01 only when defined; final byte 0x00, z_o=1, c_o=1.

Source files
------------

// File: rtl/rmw_shift_seq_pkg.sv
// Shared CPU types for the read-modify-write shift sequencer: the state
// encoding and the shift op codes.
package rmw_shift_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_RDLO, S_RDHI, S_MODIFY, S_WRHI, S_WRLO, S_FIN
   } state_t;

   typedef enum logic [1:0] {
      OP_ASL = 2'd0,
      OP_ROL = 2'd1,
      OP_LSR = 2'd2,
      OP_ROR = 2'd3
   } shop_t;

endpackage

// File: rtl/rmw_shift_seq_shift_unit.sv
// Combinational 8/16-bit shifter (ASL/ROL/LSR/ROR) with carry-out.
// When sz=1, only the low byte is shifted, and the upper result bits are zero.
module shiftUnit
   import rmw_shift_seq_pkg::*;
#(
   parameter int DBW = 16
) (
   input  logic [DBW-1:0] val,
   input  logic           sz,
   input  shop_t          op,
   input  logic           ci,
   output logic [DBW-1:0] res,
   output logic           co
);

   logic [DBW-1:0] v;
   logic           msb;
   logic [DBW-1:0] ci_top;

   always_comb begin
      v      = sz ? {{(DBW-8){1'b0}}, val[7:0]} : val;
      msb    = sz ? val[7] : val[DBW-1];
      ci_top = sz ? (DBW'(ci) << 7) : (DBW'(ci) << (DBW-1));
      res    = '0;
      co     = 1'b0;
      case (op)
         OP_ASL: begin res = v << 1;            co = msb;  end
         OP_ROL: begin res = (v << 1) | DBW'(ci); co = msb; end
         OP_LSR: begin res = v >> 1;            co = v[0]; end
         OP_ROR: begin res = (v >> 1) | ci_top; co = v[0]; end
         default: begin res = '0;               co = 1'b0; end
      endcase
      if (sz) res[DBW-1:8] = '0;
   end

endmodule

// File: rtl/rmw_shift_seq.sv
// Read-modify-write shift sequencer: reads an 8- or 16-bit operand over a byte bus,
// shifts it, and writes it back high byte first. Define RMW_DUMMY_WRITE_EN to make
// MODIFY a 6502-style dummy write of the unmodified low byte.
module rmw_shift_seq
   import rmw_shift_seq_pkg::*;
#(
   parameter int DBW = 16,
   parameter int AWB = 24
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           sz,
   input  logic [1:0]     op,
   input  logic           ci,
   input  logic [AWB-1:0] addr,
   output logic           cyc_o,
   output logic           we_o,
   output logic [AWB-1:0] adr_o,
   output logic [7:0]     dat_o,
   input  logic [7:0]     dat_i,
   input  logic           ack_i,
   output logic           busy,
   output logic           done,
   output logic [DBW-1:0] res_o,
   output logic           n_o,
   output logic           z_o,
   output logic           c_o
);

   state_t         state;
   logic           sz_r, ci_r;
   shop_t          op_r;
   logic [AWB-1:0] addr_r, addr_hi;
   logic [DBW-1:0] opnd, sh_res;
   logic           sh_c, mod_go;

   // The address wraps naturally at the AWB width.
   assign addr_hi = addr_r + AWB'(1);

`ifdef RMW_DUMMY_WRITE_EN
   assign mod_go = ack_i;
`else
   assign mod_go = 1'b1;
`endif

   shiftUnit #(.DBW(DBW)) u_shift (
      .val(opnd), .sz(sz_r), .op(op_r), .ci(ci_r), .res(sh_res), .co(sh_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cyc_o  <= 1'b0;
         we_o   <= 1'b0;
         adr_o  <= '0;
         dat_o  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         res_o  <= '0;
         n_o    <= 1'b0;
         z_o    <= 1'b0;
         c_o    <= 1'b0;
         sz_r   <= 1'b0;
         ci_r   <= 1'b0;
         op_r   <= OP_ASL;
         addr_r <= '0;
         opnd   <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               sz_r   <= sz;
               op_r   <= shop_t'(op);
               ci_r   <= ci;
               addr_r <= addr;
               opnd   <= '0;
               busy   <= 1'b1;
               cyc_o  <= 1'b1;
               we_o   <= 1'b0;
               adr_o  <= addr;
               state  <= S_RDLO;
            end
            S_RDLO: if (ack_i) begin
               opnd[7:0] <= dat_i;
               if (sz_r) begin
                  state <= S_MODIFY;
`ifdef RMW_DUMMY_WRITE_EN
                  we_o  <= 1'b1;
                  adr_o <= addr_r;
                  dat_o <= dat_i;
`else
                  cyc_o <= 1'b0;
`endif
               end else begin
                  state <= S_RDHI;
                  adr_o <= addr_hi;
               end
            end
            S_RDHI: if (ack_i) begin
               opnd[15:8] <= dat_i;
               state      <= S_MODIFY;
`ifdef RMW_DUMMY_WRITE_EN
               we_o  <= 1'b1;
               adr_o <= addr_r;
               dat_o <= opnd[7:0];
`else
               cyc_o <= 1'b0;
`endif
            end
            S_MODIFY: if (mod_go) begin
               res_o <= sh_res;
               n_o   <= sz_r ? sh_res[7] : sh_res[DBW-1];
               z_o   <= (sh_res == '0);
               c_o   <= sh_c;
               cyc_o <= 1'b1;
               we_o  <= 1'b1;
               if (sz_r) begin
                  state <= S_WRLO;
                  adr_o <= addr_r;
                  dat_o <= sh_res[7:0];
               end else begin
                  state <= S_WRHI;
                  adr_o <= addr_hi;
                  dat_o <= sh_res[15:8];
               end
            end
            S_WRHI: if (ack_i) begin
               state <= S_WRLO;
               adr_o <= addr_r;
               dat_o <= res_o[7:0];
            end
            S_WRLO: if (ack_i) begin
               state <= S_FIN;
               cyc_o <= 1'b0;
               we_o  <= 1'b0;
               done  <= 1'b1;
            end
            S_FIN: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rmw_shift_seq.sv
// Scoreboard bench for rmw_shift_seq: a byte-memory responder with
// programmable ack delay, expected writes/results queued at issue time.
module tb_rmw_shift_seq;

   typedef struct packed { logic [23:0] adr; logic [7:0] dat; } wr_t;
   typedef struct packed { logic [15:0] res; logic n; logic z; logic c; } rs_t;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sz = 1'b0, ci = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [23:0] addr = '0;
   logic        cyc_o, we_o, ack_i = 1'b0, busy, done, n_o, z_o, c_o;
   logic [23:0] adr_o;
   logic [7:0]  dat_o, dat_i = '0;
   logic [15:0] res_o;

   rmw_shift_seq #(.DBW(16), .AWB(24)) dut (
      .clk(clk), .rst(rst), .start(start), .sz(sz), .op(op), .ci(ci), .addr(addr),
      .cyc_o(cyc_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
      .ack_i(ack_i), .busy(busy), .done(done), .res_o(res_o),
      .n_o(n_o), .z_o(z_o), .c_o(c_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int ack_dly = 0;
   int cnt = 0;
   logic [7:0] mem [logic [23:0]];
   wr_t exp_w[$], obs_w[$];
   rs_t exp_r[$];
   logic [32:0] held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_w(input logic [23:0] a, input logic [7:0] d);
      exp_w.push_back('{adr: a, dat: d});
   endtask

   task automatic push_r(input logic [15:0] r, input logic n, input logic z, input logic c);
      exp_r.push_back('{res: r, n: n, z: z, c: c});
   endtask

   // Bus responder: acks after ack_dly stall cycles; checks outputs stay put while stalled.
   always @(negedge clk) begin
      if (!rst && cyc_o) begin
         if (cnt == 0) held = {we_o, adr_o, dat_o};
         else chk("stall_stable", {31'b0, we_o, adr_o, dat_o}, {31'b0, held});
         if (cnt >= ack_dly) begin
            ack_i = 1'b1;
            dat_i = mem.exists(adr_o) ? mem[adr_o] : 8'h00;
            if (we_o) begin
               mem[adr_o] = dat_o;
               obs_w.push_back('{adr: adr_o, dat: dat_o});
            end
            cnt = 0;
         end else begin
            ack_i = 1'b0;
            cnt++;
         end
      end else begin
         ack_i = 1'b0;
         cnt = 0;
      end
   end

   // Monitor: pops expectations whenever a write is acked or done is presented.
   always @(negedge clk) begin
      wr_t o, e;
      rs_t er;
      while (obs_w.size() > 0) begin
         o = obs_w.pop_front();
         if (exp_w.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write: got adr %h dat %h, none expected", o.adr, o.dat);
         end else begin
            e = exp_w.pop_front();
            chk("bus_write", {32'b0, o}, {32'b0, e});
         end
      end
      if (!rst && done) begin
         if (exp_r.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: got res %h, none expected", res_o);
         end else begin
            er = exp_r.pop_front();
            chk("result_flags", {45'b0, res_o, n_o, z_o, c_o}, {45'b0, er});
         end
      end
   end

   task automatic run(input logic s, input logic [1:0] o, input logic c,
                      input logic [23:0] a, input int hold, input logic fin_start);
      int k;
      @(negedge clk);
      sz = s; op = o; ci = c; addr = a; start = 1'b1;
      repeat (hold) @(negedge clk);
      start = 1'b0;
      k = 0;
      while (busy && k < 400) begin
         @(negedge clk);
         start = fin_start && done;
         k++;
      end
      start = 1'b0;
      if (busy) begin
         n_vec++; n_err++;
         $display("FAIL op_timeout: busy still %b, required 0", busy);
      end
      @(negedge clk);
      chk("idle_after_op", {62'b0, busy, cyc_o}, 64'd0);
   endtask

   initial begin
      int k;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      #1;
      chk("reset_ctrl", {57'b0, cyc_o, we_o, busy, done, n_o, z_o, c_o}, 64'd0);
      chk("reset_adr_dat", {32'b0, adr_o, dat_o}, 64'd0);
      chk("reset_res", {48'b0, res_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 8-bit ASL of 0x81, start held into the op (must be ignored).
      mem[24'h001234] = 8'h81;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'h001234, 8'h81);
`endif
      push_w(24'h001234, 8'h02);
      push_r(16'h0002, 1'b0, 1'b0, 1'b1);
      run(1'b1, 2'd0, 1'b0, 24'h001234, 3, 1'b0);

      // 16-bit ROR with carry-in of 0x0001.
      mem[24'h000010] = 8'h01; mem[24'h000011] = 8'h00;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'h000010, 8'h01);
`endif
      push_w(24'h000011, 8'h80);
      push_w(24'h000010, 8'h00);
      push_r(16'h8000, 1'b1, 1'b0, 1'b1);
      run(1'b0, 2'd3, 1'b1, 24'h000010, 1, 1'b0);

      // Address wrap: low byte at FFFFFF, high byte at 000000; ASL 0x1234.
      mem[24'hFFFFFF] = 8'h34; mem[24'h000000] = 8'h12;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'hFFFFFF, 8'h34);
`endif
      push_w(24'h000000, 8'h24);
      push_w(24'hFFFFFF, 8'h68);
      push_r(16'h2468, 1'b0, 1'b0, 1'b0);
      run(1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1, 1'b0);

      // Three stall cycles on every access: ROL with carry-in of 0x80C0.
      ack_dly = 3;
      mem[24'h000200] = 8'hC0; mem[24'h000201] = 8'h80;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'h000200, 8'hC0);
`endif
      push_w(24'h000201, 8'h01);
      push_w(24'h000200, 8'h81);
      push_r(16'h0181, 1'b0, 1'b0, 1'b1);
      run(1'b0, 2'd1, 1'b0 | 1'b1, 24'h000200, 1, 1'b0);

      // Reset while stalled in the high-byte write.
      mem[24'h000300] = 8'h55; mem[24'h000301] = 8'hAA;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'h000300, 8'h55);
`endif
      @(negedge clk);
      sz = 1'b0; op = 2'd2; ci = 1'b0; addr = 24'h000300; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(cyc_o && we_o && adr_o == 24'h000301) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("reached_wrhi", {40'b0, adr_o}, 64'h301);
      rst = 1'b1;
      #1;
      chk("rst_mid_ctrl", {60'b0, cyc_o, we_o, busy, done}, 64'd0);
      chk("rst_mid_outs", {16'b0, adr_o, dat_o, res_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ack_dly = 0;
      repeat (4) @(negedge clk);
      chk("no_bus_after_rst", {62'b0, cyc_o, busy}, 64'd0);

      // 8-bit LSR of 0x01 after the reset: result zero, carry out.
      mem[24'h000400] = 8'h01;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'h000400, 8'h01);
`endif
      push_w(24'h000400, 8'h00);
      push_r(16'h0000, 1'b0, 1'b1, 1'b1);
      run(1'b1, 2'd2, 1'b0, 24'h000400, 1, 1'b0);
      chk("lsr_mem_byte", {56'b0, mem[24'h000400]}, 64'h00);

      // 8-bit ROR with carry-in of 0x00, start re-asserted during FIN.
      mem[24'h000500] = 8'h00;
`ifdef RMW_DUMMY_WRITE_EN
      push_w(24'h000500, 8'h00);
`endif
      push_w(24'h000500, 8'h80);
      push_r(16'h0080, 1'b1, 1'b0, 1'b0);
      run(1'b1, 2'd3, 1'b1, 24'h000500, 1, 1'b1);
      chk("res_held_idle", {45'b0, res_o, n_o, z_o, c_o}, {45'b0, 16'h0080, 1'b1, 1'b0, 1'b0});

      repeat (3) @(negedge clk);
      chk("writes_drained", exp_w.size(), 0);
      chk("results_drained", exp_r.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
